unorm_pipe: RTL and testbench

Pipelined, multi-channel unsigned fixed-point format converter. Changes width and binary-point location, rounds when fractional bits are dropped, and saturates on overflow instead of wrapping. It sits between arithmetic stages of a datapath: valid/ready on both sides, per-channel overflow flags and a sticky overflow status.

---
 rtl/unorm_pkg.sv | 37 +++
 rtl/unorm_lane.sv | 47 ++++
 rtl/unorm_pipe.sv | 89 ++++++++
 tb/tb_unorm_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/unorm_pkg.sv
// unorm_pkg: shared helpers for the unorm_pipe format converter.
// Build option: define UNORM_PIPE_ROUND_EN to round half up when fractional
// bits are dropped; leave it undefined to truncate.
package unorm_pkg;

`ifdef UNORM_PIPE_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  // Widest saturation constant sat_const can produce.
  localparam int unsigned SAT_MAX_W = 64;

  // Width of the shifted (and possibly rounded) per-lane intermediate.
  // The rounding carry needs one extra MSB.
  function automatic int unsigned inter_width(
    input int unsigned a_width,
    input int unsigned a_scale,
    input int unsigned f_scale,
    input bit          round_en
  );
    if (f_scale >= a_scale)
      return a_width + (f_scale - a_scale);
    else
      return a_width - (a_scale - f_scale) + (round_en ? 32'd1 : 32'd0);
  endfunction

  // All-ones value of an f_width-bit word.
  function automatic logic [SAT_MAX_W-1:0] sat_const(input int unsigned f_width);
    if (f_width >= SAT_MAX_W)
      return '1;
    else
      return (SAT_MAX_W'(1) << f_width) - SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/unorm_lane.sv
// unorm_lane: per-lane combinational logic of unorm_pipe.
//   a     -> inter : binary-point shift (and rounding), feeds stage 1
//   s1    -> sat   : saturation to F_WIDTH bits, feeds stage 2
// Rounding is selected by the UNORM_PIPE_ROUND_EN macro (via unorm_pkg).
module unorm_lane
  import unorm_pkg::*;
#(
  parameter int unsigned A_WIDTH = 32,
  parameter int unsigned A_SCALE = 12,
  parameter int unsigned F_WIDTH = 16,
  parameter int unsigned F_SCALE = 8,
  localparam int unsigned IW = inter_width(A_WIDTH, A_SCALE, F_SCALE, ROUND_EN)
) (
  input  logic [A_WIDTH-1:0] a,
  output logic [IW-1:0]      inter,
  input  logic [IW-1:0]      s1,
  output logic [F_WIDTH-1:0] sat,
  output logic               ovf
);

  localparam bit          LEFT = (F_SCALE >= A_SCALE);
  localparam int unsigned SH   = LEFT ? (F_SCALE - A_SCALE) : (A_SCALE - F_SCALE);
  localparam logic [F_WIDTH-1:0] SAT = F_WIDTH'(sat_const(F_WIDTH));

  generate
    if (LEFT) begin : g_left
      assign inter = IW'(a) << SH;
    end else if (ROUND_EN) begin : g_round
      // Round half up: add the most significant dropped bit; the extra MSB of
      // inter keeps the carry so it can drive the lane into saturation.
      assign inter = IW'(a >> SH) + IW'(a[SH-1]);
    end else begin : g_trunc
      assign inter = IW'(a >> SH);
    end
  endgenerate

  generate
    if (IW > F_WIDTH) begin : g_sat
      assign ovf = |s1[IW-1:F_WIDTH];
      assign sat = ovf ? SAT : s1[F_WIDTH-1:0];
    end else begin : g_fit
      assign ovf = 1'b0;
      assign sat = F_WIDTH'(s1);
    end
  endgenerate

endmodule

// File: rtl/unorm_pipe.sv
// unorm_pipe: two-stage, multi-channel unsigned fixed-point converter with
// saturation, valid/ready handshake and a sticky overflow status.
// Build option: UNORM_PIPE_ROUND_EN enables round-half-up on right shifts.
module unorm_pipe
  import unorm_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned A_WIDTH  = 32,
  parameter int unsigned A_SCALE  = 12,
  parameter int unsigned F_WIDTH  = 16,
  parameter int unsigned F_SCALE  = 8
) (
  input  logic                         clk,
  input  logic                         reset_l,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*A_WIDTH-1:0]  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*F_WIDTH-1:0]  out_data,
  output logic [CHANNELS-1:0]          out_ovf,
  output logic                         ovf_sticky,
  input  logic                         ovf_clr
);

  localparam int unsigned IW = inter_width(A_WIDTH, A_SCALE, F_SCALE, ROUND_EN);

  logic                        s1_valid;
  logic [IW-1:0]               s1_inter   [CHANNELS];
  logic [IW-1:0]               lane_inter [CHANNELS];
  logic [CHANNELS*F_WIDTH-1:0] sat_data;
  logic [CHANNELS-1:0]         lane_ovf;
  logic                        s2_free;

  // Pure gate path from out_ready: no arithmetic between ready signals.
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    unorm_lane #(
      .A_WIDTH (A_WIDTH),
      .A_SCALE (A_SCALE),
      .F_WIDTH (F_WIDTH),
      .F_SCALE (F_SCALE)
    ) u_lane (
      .a     (in_data[k*A_WIDTH +: A_WIDTH]),
      .inter (lane_inter[k]),
      .s1    (s1_inter[k]),
      .sat   (sat_data[k*F_WIDTH +: F_WIDTH]),
      .ovf   (lane_ovf[k])
    );
  end

  // Pipeline registers: each stage loads when empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= '0;
      for (int unsigned k = 0; k < CHANNELS; k++) s1_inter[k] <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          for (int unsigned k = 0; k < CHANNELS; k++) s1_inter[k] <= lane_inter[k];
        end
      end
      if (s2_free) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= sat_data;
          out_ovf  <= lane_ovf;
        end
      end
    end
  end

  // Sticky overflow: set by an accepted beat with any lane saturated; set beats clear.
  always_ff @(posedge clk) begin
    if (!reset_l)
      ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && (|out_ovf))
      ovf_sticky <= 1'b1;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_unorm_pipe.sv
// tb_unorm_pipe: scoreboard bench for unorm_pipe. Instance A (2 lanes,
// right shift by 4) and instance B (1 lane, left shift by 4). Expected
// responses depend on UNORM_PIPE_ROUND_EN where rounding applies.
module tb_unorm_pipe;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A signals
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf_sticky, a_ovf_clr;
  logic [31:0] a_in_data;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_ovf;
  // Instance B signals
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf_sticky, b_ovf_clr;
  logic [15:0] b_in_data;
  logic [15:0] b_out_data;
  logic [0:0]  b_out_ovf;

  logic [17:0] a_q[$];
  logic [16:0] b_q[$];
  int          a_pop_cyc[$];

`ifdef UNORM_PIPE_ROUND_EN
  localparam logic [17:0] EXP_RND    = {2'b10, 8'hFF, 8'hA2};
  localparam logic        EXP_STICKY = 1'b1;
`else
  localparam logic [17:0] EXP_RND    = {2'b00, 8'hFF, 8'hA1};
  localparam logic        EXP_STICKY = 1'b0;
`endif

  unorm_pipe #(
    .CHANNELS (2), .A_WIDTH (16), .A_SCALE (8), .F_WIDTH (8), .F_SCALE (4)
  ) dut_a (
    .clk (clk), .reset_l (reset_l),
    .in_valid (a_in_valid), .in_ready (a_in_ready), .in_data (a_in_data),
    .out_valid (a_out_valid), .out_ready (a_out_ready), .out_data (a_out_data),
    .out_ovf (a_out_ovf), .ovf_sticky (a_ovf_sticky), .ovf_clr (a_ovf_clr)
  );

  unorm_pipe #(
    .CHANNELS (1), .A_WIDTH (16), .A_SCALE (4), .F_WIDTH (16), .F_SCALE (8)
  ) dut_b (
    .clk (clk), .reset_l (reset_l),
    .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data),
    .out_valid (b_out_valid), .out_ready (b_out_ready), .out_data (b_out_data),
    .out_ovf (b_out_ovf), .ovf_sticky (b_ovf_sticky), .ovf_clr (b_ovf_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor A: every presented beat must match the queue head; pop on accept.
  always @(negedge clk) begin
    if (reset_l && a_out_valid) begin
      if (a_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_beat: got %h, expected no beat (cycle %0d)",
                 {a_out_ovf, a_out_data}, cyc);
      end else begin
        chk("a_beat", 32'({a_out_ovf, a_out_data}), 32'(a_q[0]));
        if (a_out_ready) begin
          void'(a_q.pop_front());
          a_pop_cyc.push_back(cyc);
        end
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (reset_l && b_out_valid) begin
      if (b_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_beat: got %h, expected no beat (cycle %0d)",
                 {b_out_ovf, b_out_data}, cyc);
      end else begin
        chk("b_beat", 32'({b_out_ovf, b_out_data}), 32'(b_q[0]));
        if (b_out_ready) void'(b_q.pop_front());
      end
    end
  end

  task automatic send_a(input logic [31:0] d, input logic [17:0] exp, input bit rnd,
                        output int waited);
    bit acc;
    a_q.push_back(exp);
    a_in_data  = d;
    a_in_valid = 1'b1;
    waited     = 0;
    do begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
      waited++;
      if (rnd) a_out_ready = 1'($urandom_range(0, 1));
    end while (!acc && waited < 200);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL a_send_timeout: got no accept, expected accept within 200 cycles");
    end
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d, input logic [16:0] exp);
    bit acc;
    int waited = 0;
    b_q.push_back(exp);
    b_in_data  = d;
    b_in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = b_in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!acc && waited < 200);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL b_send_timeout: got no accept, expected accept within 200 cycles");
    end
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a(input bit rnd);
    int n = 0;
    while (a_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (rnd) a_out_ready = 1'($urandom_range(0, 1));
    end
    a_out_ready = 1'b1;
    chk("a_drain_left", 32'(a_q.size()), 32'd0);
  endtask

  task automatic drain_b();
    int n = 0;
    while (b_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b_drain_left", 32'(b_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int w;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1; a_ovf_clr = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1; b_ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_l = 1'b1;

    // Reset state
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_sticky",    32'(a_ovf_sticky), 32'd0);
    chk("rst_out_data",  32'(a_out_data),  32'd0);
    chk("rst_out_ovf",   32'(a_out_ovf),   32'd0);
    chk("rst_b_valid",   32'(b_out_valid), 32'd0);

    // Round vs truncate (lane0) and rounding carry into saturation (lane1); latency 2
    send_a({16'h0FF8, 16'h0A18}, EXP_RND, 1'b0, w);
    chk("lat_edge1_valid", 32'(a_out_valid), 32'd0);
    wait_cyc(1);
    chk("lat_edge2_valid", 32'(a_out_valid), 32'd1);
    wait_cyc(1);
    chk("sticky_round_carry", 32'(a_ovf_sticky), 32'(EXP_STICKY));
    a_ovf_clr = 1'b1;
    wait_cyc(1);
    a_ovf_clr = 1'b0;
    chk("sticky_clr_first", 32'(a_ovf_sticky), 32'd0);

    // Plain overflow
    send_a({16'h0000, 16'h1234}, {2'b01, 8'h00, 8'hFF}, 1'b0, w);
    wait_cyc(2);
    chk("sticky_plain_ovf", 32'(a_ovf_sticky), 32'd1);

    // Clear coinciding with a new overflowing accept: set wins
    send_a({16'h0000, 16'h1234}, {2'b01, 8'h00, 8'hFF}, 1'b0, w);
    wait_cyc(1);
    a_ovf_clr = 1'b1;
    wait_cyc(1);
    a_ovf_clr = 1'b0;
    chk("sticky_set_wins", 32'(a_ovf_sticky), 32'd1);
    a_ovf_clr = 1'b1;
    wait_cyc(1);
    a_ovf_clr = 1'b0;
    chk("sticky_clr_alone", 32'(a_ovf_sticky), 32'd0);

    // Left shift on instance B
    send_b(16'h00AB, {1'b0, 16'h0AB0});
    send_b(16'h1234, {1'b1, 16'hFFFF});
    drain_b();
    wait_cyc(1);
    chk("b_sticky", 32'(b_ovf_sticky), 32'd1);

    // Backpressure: 8 incrementing beats, random out_ready
    for (int i = 0; i < 8; i++)
      send_a({16'(16'h0F00 + i * 16), 16'(16 * (i + 1))},
             {2'b00, 8'(8'hF0 + i), 8'(i + 1)}, 1'b1, w);
    drain_a(1'b1);

    // Full throughput with out_ready=1
    a_pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      send_a({16'(i * 256), 16'(16'h0200 + i * 16)},
             {2'b00, 8'(i * 16), 8'(8'h20 + i)}, 1'b0, w);
      chk("tput_accept_cycles", 32'(w), 32'd1);
    end
    drain_a(1'b0);
    chk("tput_beats", 32'(a_pop_cyc.size()), 32'd8);
    for (int i = 1; i < 8 && i < a_pop_cyc.size(); i++)
      chk("tput_spacing", 32'(a_pop_cyc[i] - a_pop_cyc[i-1]), 32'd1);

    // Reset mid-stream with both stages full
    send_a({16'h0000, 16'h1234}, {2'b01, 8'h00, 8'hFF}, 1'b0, w);
    wait_cyc(2);
    chk("sticky_pre_reset", 32'(a_ovf_sticky), 32'd1);
    a_out_ready = 1'b0;
    send_a({16'h0300, 16'h0400}, {2'b00, 8'h30, 8'h40}, 1'b0, w);
    send_a({16'h0500, 16'h0600}, {2'b00, 8'h50, 8'h60}, 1'b0, w);
    chk("full_in_ready",  32'(a_in_ready),  32'd0);
    chk("full_out_valid", 32'(a_out_valid), 32'd1);
    reset_l = 1'b0;
    a_q.delete();
    b_q.delete();
    wait_cyc(1);
    reset_l = 1'b1;
    chk("midrst_out_valid", 32'(a_out_valid),  32'd0);
    chk("midrst_in_ready",  32'(a_in_ready),   32'd1);
    chk("midrst_sticky",    32'(a_ovf_sticky), 32'd0);
    a_out_ready = 1'b1;
    wait_cyc(6);
    chk("midrst_no_stale", 32'(a_out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
